// File: rtl/noise_reduction_ctrl_if.sv
// Capture-stream and register-write signals that feed noise_reduction_ctrl.
// The capture counters and the config master drive the master side; the controller listens on the slave side.
interface noise_reduction_ctrl_if;
  logic        iDVAL;
  logic [15:0] iX_Cont;
  logic [15:0] iY_Cont;
  logic        iCFG_WR;
  logic [1:0]  iCFG_ADDR;
  logic [15:0] iCFG_DATA;

  modport master (output iDVAL, iX_Cont, iY_Cont, iCFG_WR, iCFG_ADDR, iCFG_DATA);
  modport slave  (input  iDVAL, iX_Cont, iY_Cont, iCFG_WR, iCFG_ADDR, iCFG_DATA);
endinterface

// File: rtl/noise_reduction_ctrl.sv
// Frame-level controller for the 3x3 binary noise-reduction filter: staged config, frame sequencing, window-valid strobe.
// Build macro NR_CTRL_STATS_EN adds the completed/truncated frame counters on oFRAME_CNT and oDROP_CNT.
module noise_reduction_ctrl #(
  parameter int          IMG_WIDTH   = 640,
  parameter int          IMG_HEIGHT  = 480,
  parameter logic [14:0] DEF_THRESH  = 15'd8000,
  parameter logic [3:0]  DEF_SHALLOW = 4'd8
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  noise_reduction_ctrl_if.slave bus,
  output logic [1:0]            oMODE,
  output logic [14:0]           oTHRESH_DEEP,
  output logic [3:0]            oTHRESH_SHALLOW,
  output logic                  oWIN_VALID,
  output logic                  oFRAME_START,
  output logic                  oFRAME_DONE,
  output logic                  oBUSY,
  output logic                  oERR,
  output logic [15:0]           oFRAME_CNT,
  output logic [15:0]           oDROP_CNT
);

  typedef enum logic [2:0] {IDLE, WAIT_SOF, PRIME, RUN, DONE} stateT;

  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);

  stateT       state;
  logic [1:0]  stagedMode;
  logic [14:0] stagedDeep;
  logic [3:0]  stagedShallow;
  logic        enable;
  logic        singleShot;
  logic [15:0] colCnt;
  logic [15:0] rowCnt;
  logic [15:0] curCol;
  logic [15:0] curRow;
  logic        sof;
  logic        lastCol;
  logic        primeEnd;
  logic        frameEnd;
  logic        startEvt;
  logic        truncEvt;
  logic        loadActive;
  logic        errClr;
  logic        winRaw;
  logic        winDly;
  logic        unusedCfgBit;

  assign unusedCfgBit = bus.iCFG_DATA[15];

  // The SOF pixel itself is column 0 of row 0, so the counters hold the position of the next expected pixel.
  assign sof      = bus.iDVAL && (bus.iX_Cont == 16'd0) && (bus.iY_Cont == 16'd0);
  assign curCol   = sof ? 16'd0 : colCnt;
  assign curRow   = sof ? 16'd0 : rowCnt;
  assign lastCol  = (curCol == LAST_COL);
  assign primeEnd = bus.iDVAL && lastCol && (curRow == 16'd1);
  assign frameEnd = bus.iDVAL && lastCol && (curRow == LAST_ROW);

  assign truncEvt = sof && ((state == PRIME) || (state == RUN));
  assign startEvt = sof && ((state == WAIT_SOF) || (state == PRIME) || (state == RUN) ||
                            ((state == DONE) && enable && !singleShot));
  assign loadActive = startEvt || (state == IDLE);
  assign errClr     = bus.iCFG_WR && (bus.iCFG_ADDR == 2'd3) && bus.iCFG_DATA[2];
  assign winRaw     = bus.iDVAL && (state == RUN) && (curCol >= 16'd2);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      colCnt <= 16'd0;
      rowCnt <= 16'd0;
    end else if (bus.iDVAL) begin
      if (lastCol) begin
        colCnt <= 16'd0;
        rowCnt <= curRow + 16'd1;
      end else begin
        colCnt <= curCol + 16'd1;
        rowCnt <= curRow;
      end
    end
  end

  // Staged register file; a finishing single-shot or disabled frame drops enable unless a write lands that cycle.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      stagedMode    <= 2'd0;
      stagedDeep    <= DEF_THRESH;
      stagedShallow <= DEF_SHALLOW;
      enable        <= 1'b0;
      singleShot    <= 1'b0;
    end else begin
      if ((state == DONE) && (singleShot || !enable)) enable <= 1'b0;
      if (bus.iCFG_WR) begin
        case (bus.iCFG_ADDR)
          2'd0: stagedMode    <= bus.iCFG_DATA[1:0];
          2'd1: stagedDeep    <= bus.iCFG_DATA[14:0];
          2'd2: stagedShallow <= bus.iCFG_DATA[3:0];
          default: begin
            enable     <= bus.iCFG_DATA[0];
            singleShot <= bus.iCFG_DATA[1];
          end
        endcase
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state           <= IDLE;
      oMODE           <= 2'd0;
      oTHRESH_DEEP    <= DEF_THRESH;
      oTHRESH_SHALLOW <= DEF_SHALLOW;
      oFRAME_START    <= 1'b0;
      oFRAME_DONE     <= 1'b0;
      oBUSY           <= 1'b0;
      oERR            <= 1'b0;
    end else begin
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      if (errClr)   oERR <= 1'b0;
      if (truncEvt) oERR <= 1'b1;
      // NOTE: non-blocking assignment means a write landing on the SOF edge is not yet visible here,
      // so the frame starts with the pre-write staged value and the write waits for the next frame.
      if (loadActive) begin
        oMODE           <= stagedMode;
        oTHRESH_DEEP    <= stagedDeep;
        oTHRESH_SHALLOW <= stagedShallow;
      end
      if (startEvt) begin
        state        <= PRIME;
        oFRAME_START <= 1'b1;
        oBUSY        <= 1'b1;
      end else begin
        case (state)
          IDLE:     if (enable) state <= WAIT_SOF;
          WAIT_SOF: state <= WAIT_SOF;
          PRIME:    if (primeEnd) state <= RUN;
          RUN: begin
            if (frameEnd) begin
              state       <= DONE;
              oFRAME_DONE <= 1'b1;
              oBUSY       <= 1'b0;
            end
          end
          DONE:     state <= (singleShot || !enable) ? IDLE : WAIT_SOF;
          default: begin
            state <= IDLE;
            oBUSY <= 1'b0;
          end
        endcase
      end
    end
  end

  // Two-stage delay matches the line-buffer read plus filter-decision pipeline.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      winDly     <= 1'b0;
      oWIN_VALID <= 1'b0;
    end else begin
      winDly     <= winRaw;
      oWIN_VALID <= winDly;
    end
  end

`ifdef NR_CTRL_STATS_EN
  logic [15:0] frameCnt;
  logic [15:0] dropCnt;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      frameCnt <= 16'd0;
      dropCnt  <= 16'd0;
    end else begin
      if (state == DONE) frameCnt <= frameCnt + 16'd1;
      if (truncEvt)      dropCnt  <= dropCnt + 16'd1;
    end
  end

  assign oFRAME_CNT = frameCnt;
  assign oDROP_CNT  = dropCnt;
`else
  assign oFRAME_CNT = 16'd0;
  assign oDROP_CNT  = 16'd0;
`endif

endmodule

// File: tb/tb_noise_reduction_ctrl.sv
// Directed bench for noise_reduction_ctrl on an 8x4 frame: config staging, frame sequencing, truncation,
// single-shot and asynchronous reset, each against hand-computed expectations.
module tb_noise_reduction_ctrl;
  localparam int W = 8;
  localparam int H = 4;

`ifdef NR_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [1:0]  oMODE;
  logic [14:0] oTHRESH_DEEP;
  logic [3:0]  oTHRESH_SHALLOW;
  logic        oWIN_VALID;
  logic        oFRAME_START;
  logic        oFRAME_DONE;
  logic        oBUSY;
  logic        oERR;
  logic [15:0] oFRAME_CNT;
  logic [15:0] oDROP_CNT;

  noise_reduction_ctrl_if bus();

  noise_reduction_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .iCLK            (iCLK),
    .iRST            (iRST),
    .bus             (bus),
    .oMODE           (oMODE),
    .oTHRESH_DEEP    (oTHRESH_DEEP),
    .oTHRESH_SHALLOW (oTHRESH_SHALLOW),
    .oWIN_VALID      (oWIN_VALID),
    .oFRAME_START    (oFRAME_START),
    .oFRAME_DONE     (oFRAME_DONE),
    .oBUSY           (oBUSY),
    .oERR            (oERR),
    .oFRAME_CNT      (oFRAME_CNT),
    .oDROP_CNT       (oDROP_CNT)
  );

  always #5 iCLK = ~iCLK;

  int          cmpCount = 0;
  int          errCount = 0;
  int          startCnt = 0;
  int          doneCnt  = 0;
  int          wvCnt    = 0;
  logic        prevRaw  = 1'b0;
  logic [31:0] startDeep;
  logic [31:0] startShallow;
  logic [31:0] startFs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmpCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, clock, sample 1 ns later; raw is the bench's own window-valid prediction.
  task automatic cycle(input logic dval, input int x, input int y, input logic raw);
    bus.iDVAL   = dval;
    bus.iX_Cont = 16'(x);
    bus.iY_Cont = 16'(y);
    @(posedge iCLK);
    #1;
    bus.iCFG_WR = 1'b0;
    check("win_valid", 32'(oWIN_VALID), 32'(prevRaw));
    prevRaw = raw;
    if (oFRAME_START) startCnt++;
    if (oFRAME_DONE)  doneCnt++;
    if (oWIN_VALID)   wvCnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [15:0] data);
    bus.iCFG_WR   = 1'b1;
    bus.iCFG_ADDR = addr;
    bus.iCFG_DATA = data;
    cycle(1'b0, 0, 0, 1'b0);
  endtask

  // Streams the first n pixels of a frame back to back, optionally with one register write alongside pixel wrIdx.
  task automatic sendFrame(input logic active, input int n, input logic doWr,
                           input logic [1:0] wa, input logic [15:0] wd, input int wrIdx);
    for (int i = 0; i < n; i++) begin
      int x = i % W;
      int y = i / W;
      if (doWr && (i == wrIdx)) begin
        bus.iCFG_WR   = 1'b1;
        bus.iCFG_ADDR = wa;
        bus.iCFG_DATA = wd;
      end
      cycle(1'b1, x, y, active && (x >= 2) && (y >= 2));
      if (i == 0) begin
        startDeep    = 32'(oTHRESH_DEEP);
        startShallow = 32'(oTHRESH_SHALLOW);
        startFs      = 32'(oFRAME_START);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.iDVAL     = 1'b0;
    bus.iX_Cont   = 16'd0;
    bus.iY_Cont   = 16'd0;
    bus.iCFG_WR   = 1'b0;
    bus.iCFG_ADDR = 2'd0;
    bus.iCFG_DATA = 16'd0;

    // Reset values
    idle(3);
    check("rst_mode",    32'(oMODE),           32'd0);
    check("rst_deep",    32'(oTHRESH_DEEP),    32'd8000);
    check("rst_shallow", 32'(oTHRESH_SHALLOW), 32'd8);
    check("rst_start",   32'(oFRAME_START),    32'd0);
    check("rst_done",    32'(oFRAME_DONE),     32'd0);
    check("rst_busy",    32'(oBUSY),           32'd0);
    check("rst_err",     32'(oERR),            32'd0);
    check("rst_fcnt",    32'(oFRAME_CNT),      32'd0);
    check("rst_dcnt",    32'(oDROP_CNT),       32'd0);
    iRST = 1'b1;
    idle(1);

    // IDLE update takes two cycles from the write strobe
    writeReg(2'd0, 16'd1);
    check("mode_staged_only", 32'(oMODE), 32'd0);
    idle(1);
    check("mode_idle_follow", 32'(oMODE), 32'd1);
    check("idle_busy",        32'(oBUSY), 32'd0);

    // Two continuous frames, the second with a deep-threshold write during RUN
    writeReg(2'd3, 16'd1);
    idle(2);
    check("wait_sof_busy", 32'(oBUSY), 32'd0);
    sendFrame(1'b1, W * H, 1'b0, 2'd0, 16'd0, 0);
    check("f1_start_pulse", startFs, 32'd1);
    check("f1_done_pulse",  32'(oFRAME_DONE), 32'd1);
    check("f1_busy_done",   32'(oBUSY), 32'd0);
    idle(4);
    check("f1_win_count",   32'(wvCnt), 32'd12);
    sendFrame(1'b1, W * H, 1'b1, 2'd1, 16'd100, 2 * W + 1);
    check("f2_done_pulse",  32'(oFRAME_DONE), 32'd1);
    check("deep_held",      32'(oTHRESH_DEEP), 32'd8000);
    idle(4);
    check("two_starts",     32'(startCnt), 32'd2);
    check("two_dones",      32'(doneCnt), 32'd2);
    check("two_win_count",  32'(wvCnt), 32'd24);
    check("two_frame_cnt",  32'(oFRAME_CNT), STATS ? 32'd2 : 32'd0);
    check("two_err",        32'(oERR), 32'd0);

    // Frame 3: shallow write coincides with SOF, then truncated at row 1 col 3 with a simultaneous oERR clear
    sendFrame(1'b1, W + 3, 1'b1, 2'd2, 16'd5, 0);
    check("deep_new_frame", startDeep, 32'd100);
    check("shallow_sof_wr", startShallow, 32'd8);
    check("prime_busy",     32'(oBUSY), 32'd1);
    sendFrame(1'b1, W * H, 1'b1, 2'd3, 16'd5, 0);
    check("trunc_start",    startFs, 32'd1);
    check("trunc_reload",   startShallow, 32'd5);
    check("trunc_err_set",  32'(oERR), 32'd1);
    check("trunc_drop_cnt", 32'(oDROP_CNT), STATS ? 32'd1 : 32'd0);
    check("trunc_done",     32'(oFRAME_DONE), 32'd1);
    idle(4);
    check("trunc_starts",   32'(startCnt), 32'd4);
    check("trunc_dones",    32'(doneCnt), 32'd3);
    check("trunc_win",      32'(wvCnt), 32'd36);
    check("trunc_fcnt",     32'(oFRAME_CNT), STATS ? 32'd3 : 32'd0);
    writeReg(2'd3, 16'd5);
    check("err_cleared",    32'(oERR), 32'd0);

    // Single-shot: one frame, then IDLE with enable cleared
    writeReg(2'd3, 16'd3);
    idle(1);
    sendFrame(1'b1, W * H, 1'b0, 2'd0, 16'd0, 0);
    check("ss_done",        32'(oFRAME_DONE), 32'd1);
    idle(4);
    check("ss_starts",      32'(startCnt), 32'd5);
    check("ss_dones",       32'(doneCnt), 32'd4);
    check("ss_fcnt",        32'(oFRAME_CNT), STATS ? 32'd4 : 32'd0);
    sendFrame(1'b0, W, 1'b0, 2'd0, 16'd0, 0);
    idle(2);
    check("ss_no_restart",  32'(startCnt), 32'd5);
    check("ss_idle_busy",   32'(oBUSY), 32'd0);

    // Asynchronous reset during RUN, observed before the next clock edge
    writeReg(2'd3, 16'd1);
    idle(2);
    sendFrame(1'b1, 2 * W + 4, 1'b0, 2'd0, 16'd0, 0);
    check("run_busy",       32'(oBUSY), 32'd1);
    #2;
    iRST = 1'b0;
    #1;
    check("arst_busy",      32'(oBUSY), 32'd0);
    check("arst_mode",      32'(oMODE), 32'd0);
    check("arst_deep",      32'(oTHRESH_DEEP), 32'd8000);
    check("arst_shallow",   32'(oTHRESH_SHALLOW), 32'd8);
    check("arst_win",       32'(oWIN_VALID), 32'd0);
    check("arst_err",       32'(oERR), 32'd0);
    check("arst_start",     32'(oFRAME_START), 32'd0);
    check("arst_done",      32'(oFRAME_DONE), 32'd0);
    check("arst_fcnt",      32'(oFRAME_CNT), 32'd0);
    check("arst_dcnt",      32'(oDROP_CNT), 32'd0);
    prevRaw     = 1'b0;
    bus.iDVAL   = 1'b0;
    idle(2);
    iRST = 1'b1;
    idle(3);
    check("post_rst_busy",  32'(oBUSY), 32'd0);
    check("post_rst_start", 32'(oFRAME_START), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end
endmodule

// File: doc/noise_reduction_ctrl.md
# noise_reduction_ctrl

Frame-level controller for the 3x3 binary noise-reduction filter in the camera image-processing path. It holds the filter configuration behind a simple register-write port and applies staged values only at frame boundaries, so no frame is filtered with mixed settings. It sequences each frame through line-buffer priming and active filtering, and produces a window-valid strobe aligned to the filter output. It sits between the CCD capture counters and the noise-reduction datapath.

## Interface
- IMG_WIDTH, 640: valid pixels per line.
- IMG_HEIGHT, 480: lines per frame.
- DEF_THRESH, 8000: reset value of the deep-sum threshold.
- DEF_SHALLOW, 8: reset value of the nonzero-count threshold.
- iCLK  in  1  pixel clock; all logic is on the rising edge.
- iRST  in  1  reset; asynchronous, active-low.
- iDVAL  in  1  capture pixel valid.
- iX_Cont  in  16  capture column counter.
- iY_Cont  in  16  capture row counter.
- iCFG_WR  in  1  register write strobe, one cycle per write.
- iCFG_ADDR  in  2  register address.
- iCFG_DATA  in  16  write data.
- oMODE  out  2  active mode: 0 = shallow count, 1 = deep sum, 2 = centre pass, 3 = bypass.
- oTHRESH_DEEP  out  15  active deep threshold.
- oTHRESH_SHALLOW  out  4  active shallow threshold.
- oWIN_VALID  out  1  filter output pixel is from a full 3x3 window.
- oFRAME_START  out  1  one-cycle pulse when the shadow registers load.
- oFRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame.
- oBUSY  out  1  high in PRIME and RUN.
- oERR  out  1  sticky flag: a frame was truncated.
- oFRAME_CNT  out  16  completed frames (statistics build only).
- oDROP_CNT  out  16  truncated frames (statistics build only).

## Operation
- **Registers** (staged copies; written with iCFG_WR):
  - Address 0: mode [1:0].
  - Address 1: deep threshold [14:0].
  - Address 2: shallow threshold [3:0].
  - Address 3: control. Bit0 = enable, bit1 = single-shot, bit2 = write-1-to-clear oERR (self-clearing).
  - Reset values: mode 0, DEF_THRESH, DEF_SHALLOW, control 0.
- **SOF** (start of frame) = iDVAL && iX_Cont == 0 && iY_Cont == 0.
- **Internal counters:**
  - col counts accepted iDVAL pixels 0..IMG_WIDTH-1, then wraps to 0 and increments row.
  - Both counters clear on SOF.
- **FSM states:** IDLE, WAIT_SOF, PRIME, RUN, DONE.
  - IDLE: staged values copy to the active outputs every cycle. Moves to WAIT_SOF when enable = 1.
  - WAIT_SOF: on SOF, load active from staged, pulse oFRAME_START, go to PRIME.
  - PRIME: the first two lines fill the line buffers. When row reaches 2, go to RUN.
  - RUN: when the last pixel is accepted (row == IMG_HEIGHT-1 and col == IMG_WIDTH-1), go to DONE.
  - DONE: pulse oFRAME_DONE for one cycle.
    - If single-shot = 1 or enable = 0: clear enable and go to IDLE.
    - Otherwise go to WAIT_SOF.
- **Enable cleared mid-frame:** the current frame completes; IDLE is entered from DONE.
- **SOF in PRIME or RUN** (truncated frame):
  - Set oERR and increment oDROP_CNT.
  - Reload active registers, pulse oFRAME_START, restart PRIME with counters cleared.
- **Window validity:**
  - Window valid = iDVAL && state == RUN && col >= 2.
  - oWIN_VALID is this condition delayed two cycles, to match the filter output pipeline.
- **Counters:**
  - oFRAME_CNT increments on each DONE.
  - Both counters wrap at 16 bits.

## Timing
- **Reset values:**
  - All pulses, oBUSY, oERR, oWIN_VALID and both counters are 0.
  - Active registers take their reset values; state is IDLE.
- **Register writes:**
  - A write is accepted in any cycle; there is no backpressure.
  - The staged value is visible one cycle after iCFG_WR.
  - In IDLE, the active output follows one cycle after that (2 cycles total).
- **SOF:** oFRAME_START and the active-register update occur on the clock edge after the SOF cycle.
- **oWIN_VALID latency:** exactly 2 cycles after the qualifying iDVAL.
- **oFRAME_DONE:** asserts 1 cycle after the final pixel is accepted.
- **Simultaneous write and SOF:** the active registers load the pre-write staged value; the new write applies to the next frame.
- **Simultaneous oERR set and clear:** set wins.

## Configuration
- Macro: NR_CTRL_STATS_EN.
- Defined: oFRAME_CNT and oDROP_CNT are implemented as described.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised. All other behaviour is identical in both builds.

## Test plan
- **Reset and idle update:** reset, then write address 0 = 1 in IDLE -> oMODE = 1 two cycles after the write; all other outputs at their reset values.
- **Continuous frames:** IMG_WIDTH = 8, IMG_HEIGHT = 4, enable = 1, two full frames ->
  - one oFRAME_START per frame;
  - oWIN_VALID high for 6 pixels on each of rows 2-3, 2 cycles after each qualifying pixel;
  - oFRAME_DONE pulses twice;
  - oFRAME_CNT = 2.
- **Mid-frame write:** write address 1 = 100 during RUN -> oTHRESH_DEEP stays 8000 until the next SOF, then reads 100.
- **Truncated frame:** SOF at row 1, col 3 -> oERR = 1, oDROP_CNT = 1, PRIME restarts. Writing address 3 with bit2 = 1 clears oERR.
- **Single-shot:** control = 3 -> exactly one frame is processed, then IDLE with enable read as 0; a later SOF produces no oFRAME_START.
- **Asynchronous reset in RUN:** assert iRST mid-frame -> state IDLE and all outputs at reset values immediately, without waiting for a clock edge.
